// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: access-type encodings and FSM states.
package dmem_responder_pkg;

  typedef enum logic [2:0] {
    DM_WORD   = 3'b000,
    DM_HALF   = 3'b001,
    DM_HALF_U = 3'b010,
    DM_BYTE   = 3'b011,
    DM_BYTE_U = 3'b100
  } dm_type_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: byte enables and replicated write data for stores,
// lane select plus sign/zero extension for loads, and alignment/encoding checks.
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic [2:0]  dm_type,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] wdata,
  input  logic [31:0] word_in,
  output logic [3:0]  byte_en,
  output logic [31:0] wword,
  output logic [31:0] rword,
  output logic        misalign,
  output logic        bad_type
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  assign rbyte = word_in[{addr_lo, 3'b000} +: 8];
  assign rhalf = word_in[{addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    byte_en  = 4'b0000;
    wword    = 32'h0;
    rword    = 32'h0;
    misalign = 1'b0;
    bad_type = 1'b0;
    case (dm_type)
      DM_WORD: begin
        byte_en  = 4'b1111;
        wword    = wdata;
        rword    = word_in;
        misalign = |addr_lo;
      end
      DM_HALF, DM_HALF_U: begin
        // Replicating the halfword lets the byte enables alone pick the lane pair.
        byte_en  = addr_lo[1] ? 4'b1100 : 4'b0011;
        wword    = {2{wdata[15:0]}};
        rword    = (dm_type == DM_HALF) ? {{16{rhalf[15]}}, rhalf} : {16'h0, rhalf};
        misalign = addr_lo[0];
      end
      DM_BYTE, DM_BYTE_U: begin
        byte_en  = 4'b0001 << addr_lo;
        wword    = {4{wdata[7:0]}};
        rword    = (dm_type == DM_BYTE) ? {{24{rbyte[7]}}, rbyte} : {24'h0, rbyte};
      end
      default: bad_type = 1'b1;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: latches a request, waits WAIT_CYCLES, performs the access and
// returns rdata/err with a one-cycle ready pulse; a DONE cycle keeps held requests from re-firing.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_r,
  input  logic        mem_w,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [2:0]  dm_type,
  output logic [31:0] rdata,
  output logic        ready,
  output logic        err
);

  localparam int unsigned IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  state_e           state;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      lat_addr;
  logic [31:0]      lat_wdata;
  logic [2:0]       lat_type;
  logic             lat_w;
  logic             lat_conflict;

  logic [31:0]      ram [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic             in_range;
  logic             fault;
  logic             finish;
  logic             ram_we;
  logic [3:0]       byte_en;
  logic [31:0]      wword;
  logic [31:0]      rword;
  logic             misalign;
  logic             bad_type;

  assign idx      = lat_addr[IDX_W+1:2];
  assign in_range = {2'b00, lat_addr[31:2]} < DEPTH_WORDS;
  assign fault    = lat_conflict | misalign | bad_type | ~in_range;
  assign finish   = (state == BUSY) && (cnt == '0);
  assign ram_we   = finish && lat_w && !fault;

  dmem_lane_align u_align (
    .dm_type  (lat_type),
    .addr_lo  (lat_addr[1:0]),
    .wdata    (lat_wdata),
    .word_in  (ram[idx]),
    .byte_en  (byte_en),
    .wword    (wword),
    .rword    (rword),
    .misalign (misalign),
    .bad_type (bad_type)
  );

  // RAM has no reset; contents survive reset by design.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (byte_en[i]) ram[idx][8*i +: 8] <= wword[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      ready        <= 1'b0;
      err          <= 1'b0;
      rdata        <= 32'h0;
      lat_addr     <= 32'h0;
      lat_wdata    <= 32'h0;
      lat_type     <= 3'b000;
      lat_w        <= 1'b0;
      lat_conflict <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          if (mem_r || mem_w) begin
            lat_addr     <= addr;
            lat_wdata    <= wdata;
            lat_type     <= dm_type;
            lat_w        <= mem_w;
            lat_conflict <= mem_r && mem_w;
            cnt          <= CNT_W'(WAIT_CYCLES);
            state        <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            ready <= 1'b1;
            err   <= fault;
            rdata <= (fault || lat_w) ? 32'h0 : rword;
            state <= DONE;
          end
        end
        DONE: begin
          ready <= 1'b0;
          err   <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: two instances (WAIT_CYCLES 0 and 3) against a byte-array reference model.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int W0    = 0;
  localparam int W1    = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_r   [2];
  logic        mem_w   [2];
  logic [31:0] addr    [2];
  logic [31:0] wdata   [2];
  logic [2:0]  dm_type [2];
  logic [31:0] rdata   [2];
  logic        ready   [2];
  logic        err     [2];

  int err_cnt = 0;
  int chk_cnt = 0;

  logic [32:0] q0 [$];
  logic [32:0] q1 [$];
  logic [7:0]  mb [2][4*DEPTH];

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W0)) u_dut0 (
    .clk(clk), .reset(reset), .mem_r(mem_r[0]), .mem_w(mem_w[0]), .addr(addr[0]),
    .wdata(wdata[0]), .dm_type(dm_type[0]), .rdata(rdata[0]), .ready(ready[0]), .err(err[0])
  );

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1)) u_dut1 (
    .clk(clk), .reset(reset), .mem_r(mem_r[1]), .mem_w(mem_w[1]), .addr(addr[1]),
    .wdata(wdata[1]), .dm_type(dm_type[1]), .rdata(rdata[1]), .ready(ready[1]), .err(err[1])
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: memory as a flat byte array, access size from the type.
  function automatic logic [32:0] model(input int d, input logic r, input logic w,
                                        input logic [31:0] a, input logic [31:0] wd,
                                        input logic [2:0] t);
    int sz;
    logic [31:0] v;
    case (t)
      3'd0:       sz = 4;
      3'd1, 3'd2: sz = 2;
      3'd3, 3'd4: sz = 1;
      default:    return {1'b1, 32'h0};
    endcase
    if (r && w) return {1'b1, 32'h0};
    if ((a % 32'(sz)) != 0) return {1'b1, 32'h0};
    if (a >= 32'(4*DEPTH)) return {1'b1, 32'h0};
    if (w) begin
      for (int i = 0; i < sz; i++) mb[d][int'(a) + i] = wd[8*i +: 8];
      return {1'b0, 32'h0};
    end
    v = 32'h0;
    for (int i = 0; i < sz; i++) v = v | (32'(mb[d][int'(a) + i]) << (8*i));
    if (t == 3'd1 && v[15]) v = v | 32'hFFFF_0000;
    if (t == 3'd3 && v[7])  v = v | 32'hFFFF_FF00;
    return {1'b0, v};
  endfunction

  // Scoreboard monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (ready[d] === 1'b1) begin
        if ((d == 0 ? q0.size() : q1.size()) == 0) begin
          chk_cnt++;
          err_cnt++;
          $display("FAIL rsp%0d: unexpected ready, err=%b rdata=%h", d, err[d], rdata[d]);
        end else begin
          chk($sformatf("rsp%0d", d), {31'h0, err[d], rdata[d]},
              {31'h0, (d == 0) ? q0.pop_front() : q1.pop_front()});
        end
      end
    end
  end

  task automatic txn(input int d, input logic r, input logic w, input logic [31:0] a,
                     input logic [31:0] wd, input logic [2:0] t, output logic [32:0] obs);
    logic [32:0] e;
    int lat;
    e = model(d, r, w, a, wd, t);
    if (d == 0) q0.push_back(e); else q1.push_back(e);
    @(negedge clk);
    mem_r[d] = r; mem_w[d] = w; addr[d] = a; wdata[d] = wd; dm_type[d] = t;
    @(posedge clk);
    #1;
    // Request stays asserted, but its payload changes after acceptance.
    addr[d] = $urandom(); wdata[d] = $urandom(); dm_type[d] = 3'($urandom_range(0, 7));
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (ready[d] !== 1'b1 && lat < 40);
    obs = {err[d], rdata[d]};
    chk($sformatf("latency%0d", d), 64'(lat), 64'((d == 0 ? W0 : W1) + 1));
    @(negedge clk);
    mem_r[d] = 1'b0; mem_w[d] = 1'b0;
  endtask

  task automatic rand_txn(input int d);
    logic [31:0] a;
    logic [2:0]  t;
    logic        r, w;
    logic [32:0] obs;
    int sel;
    t = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
    a = ($urandom_range(0, 19) == 0) ? 32'(4*DEPTH + $urandom_range(0, 7)) :
        32'($urandom_range(0, 4*DEPTH - 1));
    sel = $urandom_range(0, 9);
    r = (sel == 0) || (sel > 4);
    w = (sel <= 4);
    txn(d, r, w, a, $urandom(), t, obs);
  endtask

  logic [32:0] obs;
  int t0, t1;

  initial begin
    for (int d = 0; d < 2; d++) begin
      mem_r[d] = 1'b0; mem_w[d] = 1'b0; addr[d] = 32'h0; wdata[d] = 32'h0; dm_type[d] = 3'd0;
    end
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_ready%0d", d), 64'(ready[d]), 64'd0);
      chk($sformatf("rst_err%0d", d),   64'(err[d]),   64'd0);
      chk($sformatf("rst_rdata%0d", d), 64'(rdata[d]), 64'd0);
    end
    @(negedge clk);
    reset = 1'b0;

    for (int d = 0; d < 2; d++)
      for (int k = 0; k < DEPTH; k++) txn(d, 1'b0, 1'b1, 32'(4*k), $urandom(), 3'd0, obs);

    // Directed accesses on the zero-wait instance.
    txn(0, 0, 1, 32'h10, 32'h1234_5678, 3'd0, obs);
    txn(0, 1, 0, 32'h10, 32'h0, 3'd0, obs);
    chk("word_rd", 64'(obs), {31'h0, 33'h0_1234_5678});
    txn(0, 0, 1, 32'h20, 32'h0, 3'd0, obs);
    txn(0, 0, 1, 32'h21, 32'hFFFF_FF80, 3'd3, obs);
    txn(0, 1, 0, 32'h21, 32'h0, 3'd3, obs);
    chk("byte_s", 64'(obs), {31'h0, 33'h0_FFFF_FF80});
    txn(0, 1, 0, 32'h21, 32'h0, 3'd4, obs);
    chk("byte_u", 64'(obs), {31'h0, 33'h0_0000_0080});
    txn(0, 0, 1, 32'h22, 32'h0000_8001, 3'd1, obs);
    txn(0, 1, 0, 32'h22, 32'h0, 3'd1, obs);
    chk("half_s", 64'(obs), {31'h0, 33'h0_FFFF_8001});
    txn(0, 1, 0, 32'h22, 32'h0, 3'd2, obs);
    chk("half_u", 64'(obs), {31'h0, 33'h0_0000_8001});
    txn(0, 1, 0, 32'h20, 32'h0, 3'd0, obs);
    chk("word_mix", 64'(obs), {31'h0, 33'h0_8001_8000});
    txn(0, 0, 1, 32'h13, 32'hDEAD_BEEF, 3'd0, obs);
    chk("misal_word", 64'(obs), {31'h0, 33'h1_0000_0000});
    txn(0, 1, 0, 32'h15, 32'h0, 3'd1, obs);
    chk("misal_half", 64'(obs), {31'h0, 33'h1_0000_0000});
    txn(0, 0, 1, 32'(4*DEPTH), 32'hDEAD_BEEF, 3'd0, obs);
    chk("range", 64'(obs), {31'h0, 33'h1_0000_0000});
    txn(0, 1, 1, 32'h10, 32'hDEAD_BEEF, 3'd0, obs);
    chk("both", 64'(obs), {31'h0, 33'h1_0000_0000});
    txn(0, 0, 1, 32'h10, 32'hDEAD_BEEF, 3'd6, obs);
    chk("bad_type", 64'(obs), {31'h0, 33'h1_0000_0000});
    txn(0, 1, 0, 32'h10, 32'h0, 3'd0, obs);
    chk("unchanged", 64'(obs), {31'h0, 33'h0_1234_5678});

    // Held read on the wait-state instance: DONE must not re-accept it.
    q1.push_back(model(1, 1, 0, 32'h40, 32'h0, 3'd0));
    q1.push_back(model(1, 1, 0, 32'h40, 32'h0, 3'd0));
    @(negedge clk);
    mem_r[1] = 1'b1; addr[1] = 32'h40; dm_type[1] = 3'd0;
    t0 = -1; t1 = -1;
    for (int k = 0; k < 40 && t1 < 0; k++) begin
      @(posedge clk);
      #1;
      if (ready[1] === 1'b1) begin
        if (t0 < 0) t0 = k; else t1 = k;
      end
    end
    @(negedge clk);
    mem_r[1] = 1'b0;
    chk("held_first", 64'(t0), 64'(W1 + 1));
    chk("held_gap", 64'(t1 - t0), 64'(W1 + 3));

    // Reset in the middle of a write's wait period.
    txn(1, 0, 1, 32'h40, 32'hAAAA_AAAA, 3'd0, obs);
    txn(1, 1, 0, 32'h40, 32'h0, 3'd0, obs);
    chk("pre_rst_rd", 64'(obs), {31'h0, 33'h0_AAAA_AAAA});
    @(negedge clk);
    mem_w[1] = 1'b1; addr[1] = 32'h40; wdata[1] = 32'h5555_5555; dm_type[1] = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("abort_ready", 64'(ready[1]), 64'd0);
    chk("abort_err",   64'(err[1]),   64'd0);
    chk("abort_rdata", 64'(rdata[1]), 64'd0);
    @(negedge clk);
    mem_w[1] = 1'b0;
    reset = 1'b0;
    txn(1, 1, 0, 32'h40, 32'h0, 3'd0, obs);
    chk("post_rst_rd", 64'(obs), {31'h0, 33'h0_AAAA_AAAA});

    for (int n = 0; n < 150; n++) begin
      rand_txn(0);
      rand_txn(1);
    end

    repeat (4) @(posedge clk);
    chk("q0_empty", 64'(q0.size()), 64'd0);
    chk("q1_empty", 64'(q1.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
